sa_vc_credit_ctrl: RTL and testbench
====================================

SA_VC_CREDIT_CTRL -- requirements
Module: sa_vc_credit_ctrl

Interface
REQ-001 The module SHALL have parameter VC_NUM, default 4, giving the number of downstream VCs on this output port.
REQ-002 The module SHALL have parameter VC_DEPTH, default 4, giving the downstream buffer depth per VC in flits.
REQ-003 The module SHALL have parameter VC_ID_W, default $clog2(VC_NUM) (minimum 1), giving the VC index width.
REQ-004 The module SHALL have parameter CNT_W, default $clog2(VC_DEPTH+1), giving the credit counter width.
REQ-005 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port alloc_req_vld_i, input, 1 bit: a head flit granted by switch allocation requests a downstream VC.
REQ-008 The module SHALL have port alloc_req_vc_mask_i, input, VC_NUM bits: VCs the requester may use.
REQ-009 The module SHALL have port alloc_grt_vld_o, output, 1 bit: VC granted this cycle.
REQ-010 The module SHALL have port alloc_grt_vc_id_o, output, VC_ID_W bits: granted VC index.
REQ-011 The module SHALL have port flit_send_vld_i, input, 1 bit: a flit leaves on this port.
REQ-012 The module SHALL have port flit_send_vc_id_i, input, VC_ID_W bits: VC of the sent flit.
REQ-013 The module SHALL have port flit_send_tail_i, input, 1 bit: the sent flit is a tail (a single-flit packet counts as tail).
REQ-014 The module SHALL have port credit_ret_vld_i, input, 1 bit: one credit returned from downstream.
REQ-015 The module SHALL have port credit_ret_vc_id_i, input, VC_ID_W bits: VC of the returned credit.
REQ-016 The module SHALL have port vc_credit_avail_o, output, VC_NUM bits: per VC, credit counter > 0.
REQ-017 The module SHALL have port vc_idle_o, output, VC_NUM bits: per VC, state == IDLE.
REQ-018 The module SHALL have port err_o, output, 1 bit: sticky protocol error flag.

Function
REQ-019 Each VC SHALL hold a credit counter (0..VC_DEPTH) and a state drawn from IDLE, ACTIVE and DRAIN.
REQ-020 A VC SHALL be eligible when its state is IDLE, its credit == VC_DEPTH and its alloc_req_vc_mask_i bit is 1.
REQ-021 alloc_grt_vld_o SHALL be combinational and equal to alloc_req_vld_i AND (any VC eligible), with zero-cycle latency.
REQ-022 The grant SHALL select the first eligible VC at or after rr_ptr, wrapping from VC_NUM-1 to 0.
REQ-023 alloc_grt_vc_id_o SHALL equal that VC index; it SHALL be 0 when alloc_grt_vld_o == 0.
REQ-024 On a grant, rr_ptr SHALL become (grant index + 1) mod VC_NUM at the next edge; otherwise rr_ptr SHALL hold.
REQ-025 On a grant, the granted VC SHALL transition IDLE -> ACTIVE at the next edge.
REQ-026 A valid flit send on an ACTIVE VC with credit > 0 SHALL decrement that VC's credit by 1.
REQ-027 If that send has flit_send_tail_i == 1, the VC SHALL transition ACTIVE -> DRAIN.
REQ-028 A credit return with credit < VC_DEPTH SHALL increment that VC's credit by 1.
REQ-029 A simultaneous legal send and return on the same VC SHALL leave its credit unchanged.
REQ-030 A VC in DRAIN whose registered credit == VC_DEPTH SHALL transition DRAIN -> IDLE at the next edge, so it becomes grantable one cycle after its credits refill.
REQ-031 A send on a VC with credit == 0 SHALL set err_o and SHALL leave the counter at 0 and the state unchanged.
REQ-032 A send on a VC not in ACTIVE SHALL set err_o and SHALL leave the counter and state unchanged.
REQ-033 A return on a VC with credit == VC_DEPTH SHALL set err_o and SHALL leave the counter unchanged.
REQ-034 err_o SHALL remain 1 until reset.
REQ-035 A send in the grant cycle on the newly granted VC SHALL be treated as a send on a non-ACTIVE VC (error), because the VC becomes ACTIVE only at the next edge.
REQ-036 vc_credit_avail_o and vc_idle_o SHALL be driven directly from registered state, with no combinational path from inputs.

Reset
REQ-037 While rst == 1, asynchronously, all credits SHALL be VC_DEPTH, all states IDLE, rr_ptr 0 and err_o 0.
REQ-038 During reset, vc_credit_avail_o SHALL be all ones and vc_idle_o SHALL be all ones.
REQ-039 During reset, alloc_grt_vld_o SHALL follow REQ-021 using the reset state.
REQ-040 Reset asserted mid-packet SHALL discard all ACTIVE/DRAIN state and credit deficits, with no err_o.

Verification
REQ-041 The bench SHALL cover this scenario: after reset, req with mask 4'b1111 -> grant VC0; the next cycle, the same request -> grant VC1; rr_ptr wraps after VC3 back to VC0.
REQ-042 The bench SHALL cover this scenario: mask 4'b0100 while VC2 is ACTIVE -> alloc_grt_vld_o 0; VC2 reaches IDLE with credit 4 -> a grant of VC2 in the same cycle the request is present.
REQ-043 The bench SHALL cover this scenario: grant VC1, then send 4 flits (tail on the 4th) -> credit 4,3,2,1,0, state DRAIN, vc_credit_avail_o[1] 0; 4 returns -> credit 4; one cycle later vc_idle_o[1] 1.
REQ-044 The bench SHALL cover this scenario: VC0 ACTIVE with credit 2, simultaneous send and return on VC0 -> credit stays 2 and err_o stays 0.
REQ-045 The bench SHALL cover this scenario: a send on VC3 while IDLE, a send at credit 0, and a return at credit 4 -> each sets err_o with counters unchanged; err_o holds until rst.
REQ-046 The bench SHALL cover this scenario: rst pulsed while VC2 is in DRAIN with credit 1 -> asynchronously credit 4, vc_idle_o 4'b1111, err_o 0.

Source files
------------

// File: rtl/sa_vc_credit_ctrl.sv
// Output-port VC allocator and credit tracker for a switch-allocated router port.
// Grants whole downstream VCs round-robin and tracks per-VC credits and packet state.
//
// state     | meaning
// ST_IDLE   | VC free; grantable once its credits are full
// ST_ACTIVE | VC owned by a packet; flits may be sent while credits remain
// ST_DRAIN  | tail sent; waiting for downstream to return all credits
module sa_vc_credit_ctrl #(
  parameter int VC_NUM   = 4,
  parameter int VC_DEPTH = 4,
  parameter int VC_ID_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int CNT_W    = $clog2(VC_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_req_vld_i,
  input  logic [VC_NUM-1:0]  alloc_req_vc_mask_i,
  output logic               alloc_grt_vld_o,
  output logic [VC_ID_W-1:0] alloc_grt_vc_id_o,
  input  logic               flit_send_vld_i,
  input  logic [VC_ID_W-1:0] flit_send_vc_id_i,
  input  logic               flit_send_tail_i,
  input  logic               credit_ret_vld_i,
  input  logic [VC_ID_W-1:0] credit_ret_vc_id_i,
  output logic [VC_NUM-1:0]  vc_credit_avail_o,
  output logic [VC_NUM-1:0]  vc_idle_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } vc_state_e;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(VC_DEPTH);

  logic [CNT_W-1:0]   credit_q [VC_NUM];
  logic [CNT_W-1:0]   credit_d [VC_NUM];
  vc_state_e          state_q  [VC_NUM];
  vc_state_e          state_d  [VC_NUM];
  logic [VC_ID_W-1:0] rr_ptr_q;
  logic [VC_ID_W-1:0] rr_ptr_d;
  logic               err_q;
  logic               err_d;

  logic [VC_NUM-1:0]  eligible;
  logic               gnt_found;
  logic [VC_ID_W-1:0] gnt_idx;
  logic               grt_vld;
  logic [VC_NUM-1:0]  grant_vec;

  logic [VC_NUM-1:0]  send_hit;
  logic [VC_NUM-1:0]  send_ok;
  logic [VC_NUM-1:0]  send_err;
  logic [VC_NUM-1:0]  ret_hit;
  logic [VC_NUM-1:0]  ret_ok;
  logic [VC_NUM-1:0]  ret_err;

  always_comb begin
    eligible = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      eligible[v] = (state_q[v] == ST_IDLE) && (credit_q[v] == FULL) &&
                    alloc_req_vc_mask_i[v];
    end
  end

  // Two passes: first eligible at or above the pointer, else lowest eligible overall.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (!gnt_found && eligible[v] && (VC_ID_W'(v) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = VC_ID_W'(v);
      end
    end
    for (int v = 0; v < VC_NUM; v++) begin
      if (!gnt_found && eligible[v]) begin
        gnt_found = 1'b1;
        gnt_idx   = VC_ID_W'(v);
      end
    end
  end

  always_comb begin
    grt_vld   = alloc_req_vld_i && gnt_found;
    grant_vec = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      grant_vec[v] = grt_vld && (gnt_idx == VC_ID_W'(v));
    end
    rr_ptr_d = rr_ptr_q;
    if (grt_vld) begin
      rr_ptr_d = (gnt_idx == VC_ID_W'(VC_NUM - 1)) ? '0 : gnt_idx + VC_ID_W'(1);
    end
  end

  assign alloc_grt_vld_o   = grt_vld;
  assign alloc_grt_vc_id_o = grt_vld ? gnt_idx : '0;

  always_comb begin
    send_hit = '0;
    send_ok  = '0;
    send_err = '0;
    ret_hit  = '0;
    ret_ok   = '0;
    ret_err  = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      send_hit[v] = flit_send_vld_i && (flit_send_vc_id_i == VC_ID_W'(v));
      ret_hit[v]  = credit_ret_vld_i && (credit_ret_vc_id_i == VC_ID_W'(v));
      send_ok[v]  = send_hit[v] && (state_q[v] == ST_ACTIVE) && (credit_q[v] != '0);
      send_err[v] = send_hit[v] && !send_ok[v];
      ret_ok[v]   = ret_hit[v] && (credit_q[v] != FULL);
      ret_err[v]  = ret_hit[v] && !ret_ok[v];
    end
  end

  always_comb begin
    err_d = err_q;
    // An index that names no VC is as illegal as one that names a busy or empty VC.
    if ((flit_send_vld_i && (send_hit == '0)) || (credit_ret_vld_i && (ret_hit == '0))) begin
      err_d = 1'b1;
    end
    for (int v = 0; v < VC_NUM; v++) begin
      credit_d[v] = credit_q[v];
      state_d[v]  = state_q[v];
      if (send_ok[v] && !ret_ok[v]) begin
        credit_d[v] = credit_q[v] - CNT_W'(1);
      end else if (ret_ok[v] && !send_ok[v]) begin
        credit_d[v] = credit_q[v] + CNT_W'(1);
      end
      if (send_err[v] || ret_err[v]) begin
        err_d = 1'b1;
      end
      case (state_q[v])
        ST_IDLE:   if (grant_vec[v]) state_d[v] = ST_ACTIVE;
        ST_ACTIVE: if (send_ok[v] && flit_send_tail_i) state_d[v] = ST_DRAIN;
        ST_DRAIN:  if (credit_q[v] == FULL) state_d[v] = ST_IDLE;
        default:   state_d[v] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= FULL;
        state_q[v]  <= ST_IDLE;
      end
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        credit_q[v] <= credit_d[v];
        state_q[v]  <= state_d[v];
      end
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    vc_credit_avail_o = '0;
    vc_idle_o         = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      vc_credit_avail_o[v] = (credit_q[v] != '0);
      vc_idle_o[v]         = (state_q[v] == ST_IDLE);
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_sa_vc_credit_ctrl.sv
// Directed vector bench for sa_vc_credit_ctrl: grant arbitration, credit flow and error cases.
module tb_sa_vc_credit_ctrl;

  logic       clk;
  logic       rst;
  logic       alloc_req_vld_i;
  logic [3:0] alloc_req_vc_mask_i;
  logic       alloc_grt_vld_o;
  logic [1:0] alloc_grt_vc_id_o;
  logic       flit_send_vld_i;
  logic [1:0] flit_send_vc_id_i;
  logic       flit_send_tail_i;
  logic       credit_ret_vld_i;
  logic [1:0] credit_ret_vc_id_i;
  logic [3:0] vc_credit_avail_o;
  logic [3:0] vc_idle_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] mask;
    int         snd;
    logic       tail;
    int         ret;
    logic       exp_gv;
    int         exp_gid;
    logic [3:0] exp_avail;
    logic [3:0] exp_idle;
    logic       exp_err;
    int         cvc;
    int         exp_cred;
  } vec_t;

  vec_t tbl [$];

  sa_vc_credit_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .alloc_req_vld_i     (alloc_req_vld_i),
    .alloc_req_vc_mask_i (alloc_req_vc_mask_i),
    .alloc_grt_vld_o     (alloc_grt_vld_o),
    .alloc_grt_vc_id_o   (alloc_grt_vc_id_o),
    .flit_send_vld_i     (flit_send_vld_i),
    .flit_send_vc_id_i   (flit_send_vc_id_i),
    .flit_send_tail_i    (flit_send_tail_i),
    .credit_ret_vld_i    (credit_ret_vld_i),
    .credit_ret_vc_id_i  (credit_ret_vc_id_i),
    .vc_credit_avail_o   (vc_credit_avail_o),
    .vc_idle_o           (vc_idle_o),
    .err_o               (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [3:0] mask, input int snd, input logic tail,
                              input int ret, input logic gv, input int gid,
                              input logic [3:0] avail, input logic [3:0] idle,
                              input logic err, input int cvc, input int cred);
    vec_t v;
    v.mask = mask; v.snd = snd; v.tail = tail; v.ret = ret;
    v.exp_gv = gv; v.exp_gid = gid; v.exp_avail = avail; v.exp_idle = idle;
    v.exp_err = err; v.cvc = cvc; v.exp_cred = cred;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    logic [31:0] s;
    logic [31:0] r;
    s = v.snd;
    r = v.ret;
    alloc_req_vld_i     = (v.mask != 4'b0000);
    alloc_req_vc_mask_i = v.mask;
    flit_send_vld_i     = (v.snd >= 0);
    flit_send_vc_id_i   = s[1:0];
    flit_send_tail_i    = v.tail;
    credit_ret_vld_i    = (v.ret >= 0);
    credit_ret_vc_id_i  = r[1:0];
  endtask

  task automatic idle_inputs();
    alloc_req_vld_i = 1'b0; alloc_req_vc_mask_i = 4'b0000;
    flit_send_vld_i = 1'b0; flit_send_vc_id_i = 2'd0; flit_send_tail_i = 1'b0;
    credit_ret_vld_i = 1'b0; credit_ret_vc_id_i = 2'd0;
  endtask

  // Called at posedge+1; grant checked mid-cycle, registered state checked after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    drive(v);
    #4;
    chk("grt_vld", idx, int'(alloc_grt_vld_o), int'(v.exp_gv));
    chk("grt_id", idx, int'(alloc_grt_vc_id_o), v.exp_gid);
    @(posedge clk);
    #1;
    chk("avail", idx, int'(vc_credit_avail_o), int'(v.exp_avail));
    chk("idle", idx, int'(vc_idle_o), int'(v.exp_idle));
    chk("err", idx, int'(err_o), int'(v.exp_err));
    chk("credit", idx, int'(dut.credit_q[v.cvc]), v.exp_cred);
    idle_inputs();
  endtask

  task automatic do_reset(input int idx);
    rst = 1'b1;
    #2;
    chk("rst_avail", idx, int'(vc_credit_avail_o), 32'hf);
    chk("rst_idle", idx, int'(vc_idle_o), 32'hf);
    chk("rst_err", idx, int'(err_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // mask, snd, tail, ret, gv, gid, avail, idle, err, cvc, credit
    tbl.push_back(mk(4'b1111, -1, 0, -1, 1, 0, 4'b1111, 4'b1110, 0, 0, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 1, 1, 4'b1111, 4'b1100, 0, 1, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 1, 2, 4'b1111, 4'b1000, 0, 2, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 1, 3, 4'b1111, 4'b0000, 0, 3, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 0, 0, 4'b1111, 4'b0000, 0, 0, 4));
    tbl.push_back(mk(4'b0000,  0, 1, -1, 0, 0, 4'b1111, 4'b0000, 0, 0, 3));
    tbl.push_back(mk(4'b0000, -1, 0,  0, 0, 0, 4'b1111, 4'b0000, 0, 0, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 0, 0, 4'b1111, 4'b0001, 0, 0, 4));
    tbl.push_back(mk(4'b1111, -1, 0, -1, 1, 0, 4'b1111, 4'b0000, 0, 0, 4));
    tbl.push_back(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1111, 4'b0000, 0, 0, 3));
    tbl.push_back(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1111, 4'b0000, 0, 0, 2));
    tbl.push_back(mk(4'b0000,  0, 0,  0, 0, 0, 4'b1111, 4'b0000, 0, 0, 2));
    tbl.push_back(mk(4'b0000,  0, 1, -1, 0, 0, 4'b1111, 4'b0000, 0, 0, 1));
    tbl.push_back(mk(4'b0000, -1, 0,  0, 0, 0, 4'b1111, 4'b0000, 0, 0, 2));
    tbl.push_back(mk(4'b0000, -1, 0,  0, 0, 0, 4'b1111, 4'b0000, 0, 0, 3));
    tbl.push_back(mk(4'b0000, -1, 0,  0, 0, 0, 4'b1111, 4'b0000, 0, 0, 4));
    tbl.push_back(mk(4'b0000, -1, 0, -1, 0, 0, 4'b1111, 4'b0001, 0, 0, 4));
    tbl.push_back(mk(4'b0100,  1, 1, -1, 0, 0, 4'b1111, 4'b0001, 0, 1, 3));
    tbl.push_back(mk(4'b0000, -1, 0,  1, 0, 0, 4'b1111, 4'b0001, 0, 1, 4));
    tbl.push_back(mk(4'b0000,  2, 1, -1, 0, 0, 4'b1111, 4'b0011, 0, 2, 3));
    tbl.push_back(mk(4'b0100, -1, 0,  2, 0, 0, 4'b1111, 4'b0011, 0, 2, 4));
    tbl.push_back(mk(4'b0100, -1, 0, -1, 0, 0, 4'b1111, 4'b0111, 0, 2, 4));
    tbl.push_back(mk(4'b0100, -1, 0, -1, 1, 2, 4'b1111, 4'b0011, 0, 2, 4));
    tbl.push_back(mk(4'b0010, -1, 0, -1, 1, 1, 4'b1111, 4'b0001, 0, 1, 4));
    tbl.push_back(mk(4'b0000,  1, 0, -1, 0, 0, 4'b1111, 4'b0001, 0, 1, 3));
    tbl.push_back(mk(4'b0000,  1, 0, -1, 0, 0, 4'b1111, 4'b0001, 0, 1, 2));
    tbl.push_back(mk(4'b0000,  1, 0, -1, 0, 0, 4'b1111, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(4'b0000,  1, 1, -1, 0, 0, 4'b1101, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(4'b0000, -1, 0,  1, 0, 0, 4'b1111, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(4'b0000, -1, 0,  1, 0, 0, 4'b1111, 4'b0001, 0, 1, 2));
    tbl.push_back(mk(4'b0000, -1, 0,  1, 0, 0, 4'b1111, 4'b0001, 0, 1, 3));
    tbl.push_back(mk(4'b0000, -1, 0,  1, 0, 0, 4'b1111, 4'b0001, 0, 1, 4));
    tbl.push_back(mk(4'b0000, -1, 0, -1, 0, 0, 4'b1111, 4'b0011, 0, 1, 4));
    tbl.push_back(mk(4'b0000,  3, 1, -1, 0, 0, 4'b1111, 4'b0011, 0, 3, 3));
    tbl.push_back(mk(4'b0000, -1, 0,  3, 0, 0, 4'b1111, 4'b0011, 0, 3, 4));
    tbl.push_back(mk(4'b0000, -1, 0, -1, 0, 0, 4'b1111, 4'b1011, 0, 3, 4));
    tbl.push_back(mk(4'b0000,  3, 0, -1, 0, 0, 4'b1111, 4'b1011, 1, 3, 4));
    tbl.push_back(mk(4'b1000, -1, 0, -1, 1, 3, 4'b1111, 4'b0011, 1, 3, 4));
    tbl.push_back(mk(4'b0000, -1, 0, -1, 0, 0, 4'b1111, 4'b0011, 1, 3, 4));

    // Reset state, and grant evaluated from the reset state while rst is held.
    alloc_req_vld_i = 1'b1;
    alloc_req_vc_mask_i = 4'b1111;
    #2;
    chk("rst_grt_vld", 0, int'(alloc_grt_vld_o), 1);
    chk("rst_grt_id", 0, int'(alloc_grt_vc_id_o), 0);
    chk("rst_avail", 0, int'(vc_credit_avail_o), 32'hf);
    chk("rst_idle", 0, int'(vc_idle_o), 32'hf);
    chk("rst_err", 0, int'(err_o), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_id", 0, int'(alloc_grt_vc_id_o), 0);
    chk("rst_hold_idle", 0, int'(vc_idle_o), 32'hf);
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Send at zero credit.
    do_reset(100);
    run_vec(mk(4'b0001, -1, 0, -1, 1, 0, 4'b1111, 4'b1110, 0, 0, 4), 101);
    run_vec(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1111, 4'b1110, 0, 0, 3), 102);
    run_vec(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1111, 4'b1110, 0, 0, 2), 103);
    run_vec(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1111, 4'b1110, 0, 0, 1), 104);
    run_vec(mk(4'b0000,  0, 0, -1, 0, 0, 4'b1110, 4'b1110, 0, 0, 0), 105);
    run_vec(mk(4'b0000,  0, 1, -1, 0, 0, 4'b1110, 4'b1110, 1, 0, 0), 106);
    run_vec(mk(4'b0000, -1, 0, -1, 0, 0, 4'b1110, 4'b1110, 1, 0, 0), 107);

    // Return at full credit.
    do_reset(200);
    run_vec(mk(4'b0000, -1, 0,  2, 0, 0, 4'b1111, 4'b1111, 1, 2, 4), 201);
    run_vec(mk(4'b1111, -1, 0, -1, 1, 0, 4'b1111, 4'b1110, 1, 2, 4), 202);

    // Send on the VC granted in the same cycle.
    do_reset(300);
    run_vec(mk(4'b0010,  1, 0, -1, 1, 1, 4'b1111, 4'b1101, 1, 1, 4), 301);

    // Asynchronous reset mid-cycle while VC2 drains with one credit.
    do_reset(400);
    run_vec(mk(4'b0100, -1, 0, -1, 1, 2, 4'b1111, 4'b1011, 0, 2, 4), 401);
    run_vec(mk(4'b0000,  2, 0, -1, 0, 0, 4'b1111, 4'b1011, 0, 2, 3), 402);
    run_vec(mk(4'b0000,  2, 0, -1, 0, 0, 4'b1111, 4'b1011, 0, 2, 2), 403);
    run_vec(mk(4'b0000,  2, 1, -1, 0, 0, 4'b1111, 4'b1011, 0, 2, 1), 404);
    chk("drain_state", 404, int'(dut.state_q[2]), 2);
    alloc_req_vld_i = 1'b1;
    alloc_req_vc_mask_i = 4'b0100;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_credit", 405, int'(dut.credit_q[2]), 4);
    chk("arst_idle", 405, int'(vc_idle_o), 32'hf);
    chk("arst_avail", 405, int'(vc_credit_avail_o), 32'hf);
    chk("arst_err", 405, int'(err_o), 0);
    chk("arst_grt_vld", 405, int'(alloc_grt_vld_o), 1);
    chk("arst_grt_id", 405, int'(alloc_grt_vc_id_o), 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    run_vec(mk(4'b1111, -1, 0, -1, 1, 0, 4'b1111, 4'b1110, 0, 0, 4), 406);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
